// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to memory over req/ack, youngest-match load forwarding.
// Push lands in one edge; mem_req follows one cycle later; forwarding is combinational from occupied entries.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_next;
  state_t            state;
  logic              push;
  logic              pop;
  logic [PW-1:0]     fwd_idx;
  logic [1:0]        unused_ld_lo;

  assign unused_ld_lo = ld_addr[1:0];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop in the same edge never makes room for a push: full is judged on the registered count.
  assign push  = st_valid & ~full;
  assign pop   = mem_req & mem_ack;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (st_valid && full) overflow <= 1'b1;
      case (state)
        IDLE: if (count != '0 || push) state <= REQ;
        REQ:  if (pop && count_next == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= st_addr;
      data_q[wr_ptr] <= st_data;
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_addr  = mem_req ? addr_q[rd_ptr] : '0;
  assign mem_wdata = mem_req ? data_q[rd_ptr] : '0;

  // Scan oldest to youngest so the last match, the youngest store, wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if (CW'(i) < count && addr_q[fwd_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipeline's MEM stage and a slow data-memory port.
- MEM-stage stores are enqueued in one cycle. They drain in order to memory over a req/ack handshake.
- MEM-stage loads snoop the buffer. The youngest matching pending store is forwarded.
- `full` feeds the stall logic, so the pipeline never issues a store into a full buffer.

Parameters:
- DEPTH, 4, number of store entries (power of 2, ≥2)
- DATA_W, 32, store data width
- ADDR_W, 32, byte address width; matching and forwarding use word address [ADDR_W-1:2]

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- st_valid  in  1  MEM-stage store request (MEM_MemWrite)
- st_addr  in  ADDR_W  store byte address (MEM_ALUResult)
- st_data  in  DATA_W  store data
- ld_addr  in  ADDR_W  MEM-stage load address for snooping
- ld_hit  out  1  a pending entry matches ld_addr word address
- ld_data  out  DATA_W  data of youngest matching entry; 0 when no hit
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky: a store was presented while full
- mem_req  out  1  drain request; head entry valid on mem_addr/mem_wdata
- mem_addr  out  ADDR_W  head entry address
- mem_wdata  out  DATA_W  head entry data
- mem_ack  in  1  memory accepted head entry this cycle

Behaviour:
- Storage: circular array of DEPTH entries {addr, data}.
  - Pointers wr_ptr and rd_ptr, width log2(DEPTH), wrap modulo DEPTH.
  - Registered count tracks occupancy.
- Reset (async, immediate):
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0, state = IDLE.
  - mem_req = 0, mem_addr = 0, mem_wdata = 0, ld_hit = 0, ld_data = 0.
  - Reset mid-drain discards all pending entries. mem_req drops without waiting for ack.
- Push: at a rising edge with st_valid=1 and full=0, write entry[wr_ptr] and advance wr_ptr.
  - `full` is evaluated from registered count. A push is refused when full, even if a pop occurs in the same cycle.
  - st_valid=1 while full: the store is dropped, overflow sets to 1 and holds until reset, and no state changes.
- Pop: at a rising edge with mem_req=1 and mem_ack=1, advance rd_ptr.
  - mem_ack while mem_req=0 is ignored.
- Count update: push and pop in the same edge leave count unchanged. Push only adds 1; pop only subtracts 1.
- Drain FSM, 2 states:
  - IDLE: mem_req=0. Next state REQ if count>0 or a push is accepted this edge; else IDLE.
  - REQ: mem_req=1; mem_addr/mem_wdata = entry[rd_ptr].
    - On mem_ack: stay REQ if (count − 1 + push) > 0, presenting the next entry next cycle with no bubble; otherwise go to IDLE.
    - Without ack: hold REQ with address and data stable, for unbounded wait.
- Latency: a store accepted at edge E into an empty buffer gives mem_req=1 in the cycle after E.
- mem_req is state-decoded (registered). mem_addr/mem_wdata come from the storage array and are 0 in IDLE.
- Forwarding (combinational):
  - Compare ld_addr[ADDR_W-1:2] against every occupied entry, including the head currently being drained.
  - Entries are occupied from rd_ptr for count slots.
  - Several matches: the youngest (closest to wr_ptr) wins.
  - A store presented in the same cycle as the load is not visible. Store-then-load ordering across stages guarantees the store was pushed an earlier cycle.
  - An entry popped at edge E stops matching after E.
- ld_hit/ld_data do not depend on any load-valid input; the consumer qualifies them with MemRead.
- Wrap-around: pointers wrap DEPTH-1 → 0. full/empty come from count, never from pointer equality.

Test Plan:
- Single store with ack held 0 for 3 cycles, then 1.
  - Push addr 0x0000_0010 / data 0xDEAD_BEEF.
  - Required: mem_req=1 from the next cycle; mem_addr=0x10 and mem_wdata=0xDEADBEEF stable for all 4 cycles.
  - After ack: count 0, empty 1, mem_req 0.
- Fill and overflow with DEPTH=4 and mem_ack=0.
  - Push 4 stores; full=1 and count=4.
  - A 5th store (addr 0x50) is dropped and overflow=1.
  - Drain with mem_ack=1 every cycle: mem_addr sequence is the first 4 addresses in order, back-to-back, 4 acks.
- Forwarding priority.
  - Push 0x20 ← 0x1111, then 0x24 ← 0x2222, then 0x20 ← 0x3333.
  - ld_addr=0x23: ld_hit=1, ld_data=0x3333.
  - ld_addr=0x30: ld_hit=0, ld_data=0.
- Simultaneous push and pop at count=2.
  - count stays 2 and entries stay in FIFO order.
  - Repeat for 10 cycles to force pointer wrap; data order is preserved.
- Reset mid-drain.
  - Assert reset asynchronously (between edges) with count=3 and mem_req=1.
  - Required: mem_req, count, and overflow go to 0 before the next edge.
  - After deassert, mem_ack=1 causes no pop and count stays 0.
- Push while full with simultaneous ack.
  - Store refused and overflow=1; count becomes 3.
  - The head advances to the second entry.
